// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - architectural GPR/HI/LO register file fed by MEM/WB, with WB->ID bypass
module wb_register_file #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_rf_enable,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_link_enable,
  input  logic [DATA_W-1:0] wb_link_data,
  input  logic              wb_hi_enable,
  input  logic [DATA_W-1:0] wb_hi_data,
  input  logic              wb_lo_enable,
  input  logic [DATA_W-1:0] wb_lo_data,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic [CNT_W-1:0]  commit_count
);

  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gpr_wr;
  logic              any_commit;

  assign gpr_wr     = wb_rf_enable && (wb_rd != 5'd0);
  assign any_commit = gpr_wr || wb_link_enable || wb_hi_enable || wb_lo_enable;

  // Link write is applied after the GPR write so it wins a collision on LINK_REG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (gpr_wr)         gpr[wb_rd]     <= wb_data;
      if (wb_link_enable) gpr[LINK_ADDR] <= wb_link_data;
      if (wb_hi_enable)   hi_q           <= wb_hi_data;
      if (wb_lo_enable)   lo_q           <= wb_lo_data;
      if (any_commit && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr,
                                                  input logic [DATA_W-1:0] stored);
    if (addr == 5'd0)                            return '0;
    else if (addr == LINK_ADDR && wb_link_enable) return wb_link_data;
    else if (wb_rf_enable && addr == wb_rd)       return wb_data;
    else                                          return stored;
  endfunction

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    hi_data = '0;
    lo_data = '0;
    if (!reset) begin
      rs_data = read_port(rs_addr, gpr[rs_addr]);
      rt_data = read_port(rt_addr, gpr[rt_addr]);
      hi_data = wb_hi_enable ? wb_hi_data : hi_q;
      lo_data = wb_lo_enable ? wb_lo_data : lo_q;
    end
  end

  assign commit_count = cnt_q;

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - scoreboard bench for wb_register_file against an array-based model
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_rf_enable, wb_link_enable, wb_hi_enable, wb_lo_enable;
  logic [4:0]  wb_rd, rs_addr, rt_addr;
  logic [31:0] wb_data, wb_link_data, wb_hi_data, wb_lo_data;
  logic [31:0] rs_data, rt_data, hi_data, lo_data;
  logic [31:0] rs_data4, rt_data4, hi_data4, lo_data4;
  logic [15:0] commit_count;
  logic [3:0]  commit_count4;

  always #5 clk = ~clk;

  wb_register_file dut (
    .clk(clk), .reset(reset),
    .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_link_enable(wb_link_enable), .wb_link_data(wb_link_data),
    .wb_hi_enable(wb_hi_enable), .wb_hi_data(wb_hi_data),
    .wb_lo_enable(wb_lo_enable), .wb_lo_data(wb_lo_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .hi_data(hi_data), .lo_data(lo_data),
    .commit_count(commit_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  wb_register_file #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_link_enable(wb_link_enable), .wb_link_data(wb_link_data),
    .wb_hi_enable(wb_hi_enable), .wb_hi_data(wb_hi_data),
    .wb_lo_enable(wb_lo_enable), .wb_lo_data(wb_lo_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data4), .rt_data(rt_data4), .hi_data(hi_data4), .lo_data(lo_data4),
    .commit_count(commit_count4)
  );

  typedef struct {
    logic [31:0] rs, rt, hi, lo;
    int          cnt, cnt4;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  int          m_cnt, m_cnt4;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (a == 31 && wb_link_enable) return wb_link_data;
    if (wb_rf_enable && a == wb_rd) return wb_data;
    return m_gpr[a];
  endfunction

  task automatic model_reset();
    foreach (m_gpr[i]) m_gpr[i] = 32'h0;
    m_hi = 0; m_lo = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  // Called at posedge+1: drive, push expected outputs for this cycle, advance model past next edge.
  task automatic step(input logic rst, input logic rf_en, input logic [4:0] rd, input logic [31:0] d,
                      input logic lk_en, input logic [31:0] lk, input logic h_en, input logic [31:0] h,
                      input logic l_en, input logic [31:0] l, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    reset = rst;
    wb_rf_enable = rf_en; wb_rd = rd; wb_data = d;
    wb_link_enable = lk_en; wb_link_data = lk;
    wb_hi_enable = h_en; wb_hi_data = h;
    wb_lo_enable = l_en; wb_lo_data = l;
    rs_addr = rs; rt_addr = rt;
    if (rst) begin
      model_reset();
      e = '{rs: 0, rt: 0, hi: 0, lo: 0, cnt: 0, cnt4: 0};
    end else begin
      e.rs = model_read(rs);
      e.rt = model_read(rt);
      e.hi = h_en ? h : m_hi;
      e.lo = l_en ? l : m_lo;
      e.cnt = m_cnt;
      e.cnt4 = m_cnt4;
      if (rf_en && rd != 0) m_gpr[rd] = d;
      if (lk_en) m_gpr[31] = lk;
      if (h_en) m_hi = h;
      if (l_en) m_lo = l;
      if ((rf_en && rd != 0) || lk_en || h_en || l_en) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    step(0, 0, 0, 32'hx, 0, 32'hx, 0, 32'hx, 0, 32'hx, rs, rt);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check32("rs_data", rs_data, e.rs);
      check32("rt_data", rt_data, e.rt);
      check32("hi_data", hi_data, e.hi);
      check32("lo_data", lo_data, e.lo);
      check_int("commit_count", int'(commit_count), e.cnt);
      check_int("commit_count4", int'(commit_count4), e.cnt4);
    end
  end

  initial begin
    model_reset();
    reset = 1'b1;
    wb_rf_enable = 0; wb_link_enable = 0; wb_hi_enable = 0; wb_lo_enable = 0;
    wb_rd = 0; wb_data = 0; wb_link_data = 0; wb_hi_data = 0; wb_lo_data = 0;
    rs_addr = 0; rt_addr = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    // Reset: write r5 then assert reset between edges
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    step(1, 1, 5, 32'h1, 1, 32'h2, 1, 32'h3, 1, 32'h4, 5, 31);
    idle(5, 31);
    // Write/read with bypass
    step(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 7, 7);
    idle(7, 0);
    // r0 never written, not counted
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    // Collision on link register
    step(0, 1, 31, 32'h1111, 1, 32'h00400008, 0, 0, 0, 0, 31, 31);
    idle(7, 31);
    // HI/LO independent
    step(0, 0, 0, 0, 0, 0, 1, 32'hA, 1, 32'hB, 0, 0);
    idle(0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hC, 0, 32'hx, 0, 0);
    idle(0, 0);
    // Randomized traffic, addresses biased to collide with the write address
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd, rs, rt;
      rd = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), rd, $urandom,
           ($urandom_range(0, 4) == 0), $urandom,
           ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 3) == 0), $urandom,
           rs, rt);
    end
    // Saturation of the narrow counter: 20 committing cycles
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 32'hx, 0, 32'hx, 1, $urandom, 0, 32'hx, 1, 2);
    idle(3, 4);
    idle(3, 4);
    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (sb.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d entries left want 0", sb.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
